// File: rtl/lsu_data_mem_pkg.sv
// Shared types and func3 encodings for the LSQ data memory and its response pipe.
// Load/store width decode is common to both ports, so it lives here as a helper.
package lsu_data_mem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_ROB_W  = 5;
    localparam int DMEM_PREG_W = 7;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [2:0]             func3;
        logic [DMEM_ROB_W-1:0]  rob_tag;
        logic [DMEM_PREG_W-1:0] pd;
    } dmem_ld_req_t;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            data;
        logic [DMEM_PREG_W-1:0] pd;
        logic [DMEM_ROB_W-1:0]  rob_tag;
        logic                   err;
    } dmem_resp_t;

    // Access size in bytes from func3[1:0]; 0 marks an encoding with no width.
    function automatic logic [2:0] f3_bytes(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   f3_bytes = 3'd1;
            2'b01:   f3_bytes = 3'd2;
            2'b10:   f3_bytes = 3'd4;
            default: f3_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_mem_resp_pipe.sv
// dmem_resp_pipe: LOAD_LAT-deep shift register of load responses; flush drops every
// in-flight valid on the same edge while the payload keeps shifting harmlessly.
module dmem_resp_pipe
    import lsu_data_mem_pkg::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  dmem_resp_t resp_in,
    output dmem_resp_t resp_out
);

    dmem_resp_t stage_d [LOAD_LAT];
    dmem_resp_t stage_q [LOAD_LAT];

    always_comb begin
        stage_d[0] = resp_in;
        for (int i = 1; i < LOAD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (flush) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign resp_out = stage_q[LOAD_LAT-1];

endmodule

// File: rtl/lsu_data_mem.sv
// lsu_data_mem: byte-addressable data memory behind the LSQ (all RV32I widths).
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module lsu_data_mem
    import lsu_data_mem_pkg::*;
#(
    parameter int MEM_BYTES = 102400,
    parameter int ADDR_W    = 32,
    parameter int LOAD_LAT  = 2,
    parameter int ROB_W     = 5,
    parameter int PREG_W    = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        st_func3,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_func3,
    input  logic [ROB_W-1:0]  ld_rob_tag,
    input  logic [PREG_W-1:0] ld_pd,
    input  logic              flush,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [PREG_W-1:0] resp_pd,
    output logic [ROB_W-1:0]  resp_rob_tag,
    output logic              resp_err,
    output logic              st_err
);

    localparam int              IDX_W   = $clog2(MEM_BYTES);
    localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);

    // The struct field widths are fixed by the package, so the ports must agree.
    if (ADDR_W != DMEM_ADDR_W || ROB_W != DMEM_ROB_W || PREG_W != DMEM_PREG_W) begin : g_cfg_check
        $error("lsu_data_mem: ADDR_W/ROB_W/PREG_W must match lsu_data_mem_pkg");
    end

    logic [7:0]      mem_q [MEM_BYTES];
    logic            st_err_d, st_err_q;

    logic [2:0]      st_bytes;
    logic [1:0]      st_last;
    logic            st_legal, st_misalign, st_ok;
    logic [ADDR_W:0] st_baddr [4];
    logic [3:0]      st_we;

    always_comb begin
        st_bytes = f3_bytes(st_func3);
        st_legal = (st_bytes != 3'd0) && !st_func3[2];
        st_last  = (st_bytes == 3'd4) ? 2'd3 : (st_bytes == 3'd2) ? 2'd1 : 2'd0;
        for (int k = 0; k < 4; k++) begin
            st_baddr[k] = {1'b0, st_addr} + (ADDR_W+1)'(k);
        end
`ifdef DMEM_ALIGN_CHECK_EN
        st_misalign = (st_bytes == 3'd2 && st_addr[0]) ||
                      (st_bytes == 3'd4 && st_addr[1:0] != 2'b00);
`else
        st_misalign = 1'b0;
`endif
        // Offsets are one bit wider than the address, so the last byte alone bounds the access.
        st_ok = st_legal && !st_misalign && (st_baddr[st_last] < MEM_END);
        for (int k = 0; k < 4; k++) begin
            st_we[k] = st_valid && st_ok && (3'(k) < st_bytes);
        end
        st_err_d = st_valid && !st_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (st_we[k]) begin
                    mem_q[st_baddr[k][IDX_W-1:0]] <= st_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_err_q <= 1'b0;
        end else begin
            st_err_q <= st_err_d;
        end
    end

    assign st_err = st_err_q;

    dmem_ld_req_t    ld_req;
    dmem_resp_t      resp_in, resp_out;
    logic [2:0]      ld_bytes;
    logic [1:0]      ld_last;
    logic            ld_legal, ld_misalign, ld_err;
    logic [ADDR_W:0] ld_baddr [4];
    logic [31:0]     ld_raw, ld_ext;

    // A committing store owns the array this cycle; the load retries next cycle.
    assign ld_ready = !st_valid && !flush;

    always_comb begin
        ld_req   = '{addr: ld_addr, func3: ld_func3, rob_tag: ld_rob_tag, pd: ld_pd};
        ld_bytes = f3_bytes(ld_req.func3);
        ld_legal = (ld_bytes != 3'd0) && !(ld_req.func3[2] && ld_req.func3[1]);
        ld_last  = (ld_bytes == 3'd4) ? 2'd3 : (ld_bytes == 3'd2) ? 2'd1 : 2'd0;
        ld_raw   = '0;
        for (int k = 0; k < 4; k++) begin
            ld_baddr[k] = {1'b0, ld_req.addr} + (ADDR_W+1)'(k);
            if (ld_baddr[k] < MEM_END) begin
                ld_raw[8*k +: 8] = mem_q[ld_baddr[k][IDX_W-1:0]];
            end
        end
`ifdef DMEM_ALIGN_CHECK_EN
        ld_misalign = (ld_bytes == 3'd2 && ld_req.addr[0]) ||
                      (ld_bytes == 3'd4 && ld_req.addr[1:0] != 2'b00);
`else
        ld_misalign = 1'b0;
`endif
        case (ld_req.func3)
            F3_LB:   ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
            F3_LH:   ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
            F3_LW:   ld_ext = ld_raw;
            F3_LBU:  ld_ext = {24'h0, ld_raw[7:0]};
            F3_LHU:  ld_ext = {16'h0, ld_raw[15:0]};
            default: ld_ext = '0;
        endcase
        ld_err = !ld_legal || ld_misalign || !(ld_baddr[ld_last] < MEM_END);

        resp_in.valid   = ld_valid && ld_ready;
        resp_in.data    = ld_err ? 32'h0 : ld_ext;
        resp_in.pd      = ld_req.pd;
        resp_in.rob_tag = ld_req.rob_tag;
        resp_in.err     = ld_err;
    end

    dmem_resp_pipe #(
        .LOAD_LAT (LOAD_LAT)
    ) u_resp_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .resp_in  (resp_in),
        .resp_out (resp_out)
    );

    assign resp_valid   = resp_out.valid;
    assign resp_data    = resp_out.data;
    assign resp_pd      = resp_out.pd;
    assign resp_rob_tag = resp_out.rob_tag;
    assign resp_err     = resp_out.err;

endmodule

// File: tb/tb_lsu_data_mem.sv
// Self-checking bench for lsu_data_mem: directed literal cases plus randomized traffic
// checked every cycle against a byte-array model with a response queue.
module tb_lsu_data_mem;
    import lsu_data_mem_pkg::*;

    localparam int MEM_BYTES = 102400;
    localparam int ADDR_W    = 32;
    localparam int LAT       = 2;
    localparam int ROB_W     = 5;
    localparam int PREG_W    = 7;
    localparam int EXP_W     = 32 + 32 + 1 + PREG_W + ROB_W;

    logic              clk, reset_n;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [2:0]        st_func3;
    logic              ld_valid, ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_func3;
    logic [ROB_W-1:0]  ld_rob_tag;
    logic [PREG_W-1:0] ld_pd;
    logic              flush;
    logic              resp_valid, resp_err, st_err;
    logic [31:0]       resp_data;
    logic [PREG_W-1:0] resp_pd;
    logic [ROB_W-1:0]  resp_rob_tag;

    lsu_data_mem #(
        .MEM_BYTES (MEM_BYTES), .ADDR_W (ADDR_W), .LOAD_LAT (LAT),
        .ROB_W (ROB_W), .PREG_W (PREG_W)
    ) dut (
        .clk (clk), .reset_n (reset_n),
        .st_valid (st_valid), .st_addr (st_addr), .st_data (st_data), .st_func3 (st_func3),
        .ld_valid (ld_valid), .ld_ready (ld_ready), .ld_addr (ld_addr), .ld_func3 (ld_func3),
        .ld_rob_tag (ld_rob_tag), .ld_pd (ld_pd), .flush (flush),
        .resp_valid (resp_valid), .resp_data (resp_data), .resp_pd (resp_pd),
        .resp_rob_tag (resp_rob_tag), .resp_err (resp_err), .st_err (st_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  mdl_mem [MEM_BYTES];
    logic [EXP_W-1:0] exp_q [$];
    logic        exp_st_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3, input bit is_store);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            3'd4:    return is_store ? 0 : 1;
            3'd5:    return is_store ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit access_bad(input logic [31:0] addr, input int size);
        bit bad;
        bad = (size == 0) || (longint'(addr) + longint'(size) - 1 >= longint'(MEM_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
        if (size != 0 && (addr % size) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic void model_load(input logic [31:0] addr, input logic [2:0] f3,
                                       output logic [31:0] data, output logic err);
        int size;
        logic [31:0] v;
        size = size_of(f3, 1'b0);
        err  = access_bad(addr, size);
        data = 32'h0;
        if (!err) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v + (32'(mdl_mem[int'(addr) + i]) << (8 * i));
            if (f3 == 3'd0 && v >= 32'd128)        data = v + 32'hFFFF_FF00;
            else if (f3 == 3'd1 && v >= 32'd32768) data = v + 32'hFFFF_0000;
            else                                   data = v;
        end
    endfunction

    function automatic logic model_store(input logic [31:0] addr, input logic [2:0] f3,
                                         input logic [31:0] data);
        int size;
        size = size_of(f3, 1'b1);
        if (access_bad(addr, size)) return 1'b1;
        for (int i = 0; i < size; i++) mdl_mem[int'(addr) + i] = 8'((data >> (8 * i)) & 32'hFF);
        return 1'b0;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        logic [31:0]      d;
        logic             er;
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            foreach (mdl_mem[i]) mdl_mem[i] = 8'h00;
            exp_st_err = 1'b0;
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_data", resp_data, 32'd0);
            chk("rst_resp_err", 32'(resp_err), 32'd0);
            chk("rst_resp_pd", 32'(resp_pd), 32'd0);
            chk("rst_resp_rob_tag", 32'(resp_rob_tag), 32'd0);
            chk("rst_st_err", 32'(st_err), 32'd0);
        end else begin
            chk("st_err", 32'(st_err), 32'(exp_st_err));
            chk("ld_ready", 32'(ld_ready), 32'(!st_valid && !flush));
            if (exp_q.size() > 0 && exp_q[0][EXP_W-1 -: 32] == 32'(cyc)) begin
                e = exp_q.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_data", resp_data, e[EXP_W-33 -: 32]);
                chk("resp_err", 32'(resp_err), 32'(e[PREG_W+ROB_W]));
                chk("resp_pd", 32'(resp_pd), 32'(e[PREG_W+ROB_W-1 -: PREG_W]));
                chk("resp_rob_tag", 32'(resp_rob_tag), 32'(e[ROB_W-1:0]));
            end else begin
                chk("resp_valid_idle", 32'(resp_valid), 32'd0);
            end
            exp_st_err = 1'b0;
            if (st_valid) exp_st_err = model_store(st_addr, st_func3, st_data);
            if (ld_valid && !st_valid && !flush) begin
                model_load(ld_addr, ld_func3, d, er);
                exp_q.push_back({32'(cyc + LAT), d, er, ld_pd, ld_rob_tag});
            end
            if (flush) exp_q.delete();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_func3 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_func3 = '0; ld_rob_tag = '0; ld_pd = '0;
        flush = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1; st_func3 = f3; st_addr = addr; st_data = data;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic store_err_chk(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, input logic exp_err);
        do_store(f3, addr, data);
        @(negedge clk);
        chk(name, 32'(st_err), 32'(exp_err));
        tick();
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        logic acc;
        int   waited;
        acc = 1'b0;
        waited = 0;
        ld_valid = 1'b1; ld_func3 = f3; ld_addr = addr;
        ld_rob_tag = ROB_W'($urandom); ld_pd = PREG_W'($urandom);
        while (!acc && waited < 8) begin
            @(negedge clk);
            acc = ld_ready;
            tick();
            waited++;
        end
        ld_valid = 1'b0;
        chk({name, "_accept"}, 32'(acc), 32'd1);
        if (acc) begin
            repeat (LAT - 1) tick();
            @(negedge clk);
            chk({name, "_valid"}, 32'(resp_valid), 32'd1);
            chk({name, "_data"}, resp_data, exp_data);
            chk({name, "_err"}, 32'(resp_err), 32'(exp_err));
            tick();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      return 32'($urandom_range(0, 63));
        else if (r == 7) return 32'(MEM_BYTES - 6 + $urandom_range(0, 8));
        else if (r == 8) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        else             return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        idle_inputs();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        do_store(F3_SW, 32'h100, 32'hDEAD_BEEF);
        load_chk("lw_100", F3_LW, 32'h100, 32'hDEAD_BEEF, 1'b0);
        load_chk("lb_103", F3_LB, 32'h103, 32'hFFFF_FFDE, 1'b0);
        load_chk("lbu_103", F3_LBU, 32'h103, 32'h0000_00DE, 1'b0);
        load_chk("lh_100", F3_LH, 32'h100, 32'hFFFF_BEEF, 1'b0);
        load_chk("lhu_102", F3_LHU, 32'h102, 32'h0000_DEAD, 1'b0);

        // Store and load in the same cycle: the load waits and then sees the new byte.
        st_valid = 1'b1; st_func3 = F3_SB; st_addr = 32'h200; st_data = 32'h55;
        ld_valid = 1'b1; ld_func3 = F3_LBU; ld_addr = 32'h200; ld_rob_tag = 5'd3; ld_pd = 7'd9;
        @(negedge clk);
        chk("same_cycle_stall", 32'(ld_ready), 32'd0);
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        chk("same_cycle_retry", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        repeat (LAT - 1) tick();
        @(negedge clk);
        chk("same_cycle_valid", 32'(resp_valid), 32'd1);
        chk("same_cycle_data", resp_data, 32'h55);
        tick();

        // Back-to-back loads with a flush one cycle after the second accept.
        cnt = 0;
        ld_valid = 1'b1; ld_func3 = F3_LW; ld_addr = 32'h100;
        @(negedge clk); cnt += int'(resp_valid); tick();
        ld_addr = 32'h104;
        @(negedge clk); cnt += int'(resp_valid); tick();
        ld_addr = 32'h108; flush = 1'b1;
        @(negedge clk); chk("flush_ready", 32'(ld_ready), 32'd0); cnt += int'(resp_valid); tick();
        flush = 1'b0; ld_valid = 1'b0;
        repeat (6) begin @(negedge clk); cnt += int'(resp_valid); tick(); end
        chk("flush_resp_count", 32'(cnt), 32'(int'(LAT <= 2) + int'(LAT <= 1)));

        // Top-of-memory range checks.
        do_store(F3_SH, 32'(MEM_BYTES - 2), 32'h0000_1234);
        load_chk("lw_top_oor", F3_LW, 32'(MEM_BYTES - 2), 32'h0, 1'b1);
        store_err_chk("sw_top_oor", F3_SW, 32'(MEM_BYTES - 2), 32'hCAFE_F00D, 1'b1);
        load_chk("lhu_top_kept", F3_LHU, 32'(MEM_BYTES - 2), 32'h0000_1234, 1'b0);
        store_err_chk("sh_top_ok", F3_SH, 32'(MEM_BYTES - 2), 32'h0000_1234, 1'b0);
        load_chk("lb_wrap", F3_LB, 32'hFFFF_FFFF, 32'h0, 1'b1);
        load_chk("ld_illegal_f3", 3'b011, 32'h100, 32'h0, 1'b1);
        store_err_chk("st_illegal_f3", 3'b100, 32'h100, 32'h1, 1'b1);
        load_chk("lw_100_after_bad_st", F3_LW, 32'h100, 32'hDEAD_BEEF, 1'b0);

        do_store(F3_SB, 32'h104, 32'h77);
`ifdef DMEM_ALIGN_CHECK_EN
        load_chk("lw_101_misaligned", F3_LW, 32'h101, 32'h0, 1'b1);
`else
        load_chk("lw_101_misaligned", F3_LW, 32'h101, 32'h77DE_ADBE, 1'b0);
`endif

        // Reset with a load in flight: no response afterwards and memory cleared.
        ld_valid = 1'b1; ld_func3 = F3_LW; ld_addr = 32'h100;
        tick();
        ld_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        cnt = 0;
        repeat (LAT + 3) begin @(negedge clk); cnt += int'(resp_valid); tick(); end
        chk("reset_kills_load", 32'(cnt), 32'd0);
        load_chk("lw_after_reset", F3_LW, 32'h100, 32'h0, 1'b0);

        // Randomized traffic, checked cycle by cycle by the compare process.
        for (int n = 0; n < 1500; n++) begin
            st_valid   = ($urandom_range(0, 3) == 0);
            st_func3   = 3'($urandom_range(0, 7));
            st_addr    = rand_addr();
            st_data    = $urandom;
            ld_valid   = ($urandom_range(0, 1) == 1);
            ld_func3   = 3'($urandom_range(0, 7));
            ld_addr    = rand_addr();
            ld_rob_tag = ROB_W'($urandom);
            ld_pd      = PREG_W'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();
        repeat (LAT + 3) tick();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
